shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_seq_pkg.sv | 37 +++
 rtl/shift_op_decode.sv | 29 ++
 rtl/shift_sequencer.sv | 121 ++++++++++++
 tb/tb_shift_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: op codes, shift-register commands,
// amount-mux selects and FSM states.
package shift_seq_pkg;

   typedef enum logic [2:0] {
      OP_SLL  = 3'b000,
      OP_SRL  = 3'b001,
      OP_SRA  = 3'b010,
      OP_SLLV = 3'b011,
      OP_SRAV = 3'b100,
      OP_LUI  = 3'b101
   } op_e;

   typedef enum logic [2:0] {
      CMD_NOP  = 3'b000,
      CMD_LOAD = 3'b001,
      CMD_SLL  = 3'b010,
      CMD_SRL  = 3'b011,
      CMD_SRA  = 3'b100
   } cmd_e;

   typedef enum logic [1:0] {
      SEL_RS    = 2'b00,
      SEL_K16   = 2'b01,
      SEL_SHAMT = 2'b10
   } sel_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_WRITE = 2'b11
   } state_e;

   localparam logic [4:0] LUI_AMT = 5'd16;

endpackage

// File: rtl/shift_op_decode.sv
// Combinational op decode: amount-mux select, data source, shift direction
// and a legal flag for the two reserved op codes.
module shift_op_decode
   import shift_seq_pkg::*;
(
   input  logic [2:0] op,
   output logic [1:0] ctrl,
   output logic       src,
   output logic [2:0] dir,
   output logic       legal
);

   always_comb begin
      ctrl  = SEL_RS;
      src   = 1'b0;
      dir   = CMD_NOP;
      legal = 1'b1;
      case (op)
         OP_SLL:  begin ctrl = SEL_SHAMT; dir = CMD_SLL; end
         OP_SRL:  begin ctrl = SEL_SHAMT; dir = CMD_SRL; end
         OP_SRA:  begin ctrl = SEL_SHAMT; dir = CMD_SRA; end
         OP_SLLV: begin ctrl = SEL_RS;    dir = CMD_SLL; end
         OP_SRAV: begin ctrl = SEL_RS;    dir = CMD_SRA; end
         OP_LUI:  begin ctrl = SEL_K16;   dir = CMD_SLL; src = 1'b1; end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Control FSM that steps an external shift register through load, shift and
// write-back for one shift instruction.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | waiting for start; all outputs quiet
//   ST_LOAD  | shift register loads its operand (ShiftOp=load)
//   ST_SHIFT | one shift command in the latched direction
//   ST_WRITE | result written to the register file, done pulses
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter bit SKIP_ZERO = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [4:0] shamt,
   input  logic [4:0] rs_amt,
   output logic [1:0] ShiftCtrl,
   output logic       ShiftSrc,
   output logic [2:0] ShiftOp,
   output logic       ShiftRegWrite,
   output logic       busy,
   output logic       done,
   output logic       err
);

   state_e     state;
   logic [2:0] op_q;
   logic [4:0] amt_q;
   logic [4:0] eff_amt;
   logic [2:0] dec_op;
   logic [1:0] dec_ctrl;
   logic       dec_src;
   logic [2:0] dec_dir;
   logic       dec_legal;

   // One decoder serves both the incoming request (IDLE) and the latched op.
   assign dec_op = (state == ST_IDLE) ? op : op_q;

   shift_op_decode u_decode (
      .op    (dec_op),
      .ctrl  (dec_ctrl),
      .src   (dec_src),
      .dir   (dec_dir),
      .legal (dec_legal)
   );

   always_comb begin
      eff_amt = '0;
      case (op)
         OP_SLL, OP_SRL, OP_SRA: eff_amt = shamt;
         OP_SLLV, OP_SRAV:       eff_amt = rs_amt;
         OP_LUI:                 eff_amt = LUI_AMT;
         default:                eff_amt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         op_q          <= '0;
         amt_q         <= '0;
         ShiftCtrl     <= SEL_RS;
         ShiftSrc      <= 1'b0;
         ShiftOp       <= CMD_NOP;
         ShiftRegWrite <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         ShiftRegWrite <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (dec_legal) begin
                     op_q      <= op;
                     amt_q     <= eff_amt;
                     ShiftCtrl <= dec_ctrl;
                     ShiftSrc  <= dec_src;
                     ShiftOp   <= CMD_LOAD;
                     busy      <= 1'b1;
                     state     <= ST_LOAD;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (SKIP_ZERO && (amt_q == '0)) begin
                  ShiftOp       <= CMD_NOP;
                  ShiftRegWrite <= 1'b1;
                  done          <= 1'b1;
                  state         <= ST_WRITE;
               end else begin
                  ShiftOp <= dec_dir;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               ShiftOp       <= CMD_NOP;
               ShiftRegWrite <= 1'b1;
               done          <= 1'b1;
               state         <= ST_WRITE;
            end
            ST_WRITE: begin
               ShiftCtrl <= SEL_RS;
               ShiftSrc  <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: directed cases with literal expectations, then random
// traffic, all checked every cycle against a queue-based operation model.
module tb_shift_sequencer;

   localparam bit SKIP = 1'b1;

   logic       clk;
   logic       reset;
   logic       start;
   logic [2:0] op;
   logic [4:0] shamt;
   logic [4:0] rs_amt;
   logic [1:0] ShiftCtrl;
   logic       ShiftSrc;
   logic [2:0] ShiftOp;
   logic       ShiftRegWrite;
   logic       busy;
   logic       done;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   shift_sequencer #(.SKIP_ZERO(SKIP)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .op            (op),
      .shamt         (shamt),
      .rs_amt        (rs_amt),
      .ShiftCtrl     (ShiftCtrl),
      .ShiftSrc      (ShiftSrc),
      .ShiftOp       (ShiftOp),
      .ShiftRegWrite (ShiftRegWrite),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Output tuple: {ShiftCtrl, ShiftSrc, ShiftOp, ShiftRegWrite, busy, done, err}
   function automatic logic [9:0] tup(input logic [1:0] c, input logic s, input logic [2:0] o,
                                      input logic w, input logic b, input logic d, input logic e);
      return {c, s, o, w, b, d, e};
   endfunction

   logic [9:0] q[$];
   logic [9:0] exp_v;
   logic       armed = 1'b0;

   // Model: an accepted op becomes a list of per-cycle output tuples, ending in
   // one quiet IDLE cycle during which a new start may be sampled.
   task automatic plan(input logic [2:0] o, input logic [4:0] sh, input logic [4:0] rs);
      logic [1:0] c;
      logic       s;
      logic [2:0] d;
      int         amt;
      c   = (o < 3) ? 2'd2 : (o < 5) ? 2'd0 : 2'd1;
      s   = (o == 3'd5);
      d   = (o == 3'd1) ? 3'd3 : ((o == 3'd2) || (o == 3'd4)) ? 3'd4 : 3'd2;
      amt = (o < 3) ? int'(sh) : (o < 5) ? int'(rs) : 16;
      q.push_back(tup(c, s, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0));
      if (!(SKIP && amt == 0))
         q.push_back(tup(c, s, d, 1'b0, 1'b1, 1'b0, 1'b0));
      q.push_back(tup(c, s, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
      q.push_back(10'd0);
   endtask

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         exp_v = 10'd0;
         armed = 1'b1;
      end else if (q.size() != 0) begin
         exp_v = q.pop_front();
      end else if (start) begin
         if (op <= 3'd5) begin
            plan(op, shamt, rs_amt);
            exp_v = q.pop_front();
         end else begin
            exp_v = 10'd1;
         end
      end else begin
         exp_v = 10'd0;
      end
      #1;
      if (armed)
         chk("cycle", {ShiftCtrl, ShiftSrc, ShiftOp, ShiftRegWrite, busy, done, err}, exp_v);
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic go(input logic [2:0] o, input logic [4:0] sh, input logic [4:0] rs);
      start  = 1'b1;
      op     = o;
      shamt  = sh;
      rs_amt = rs;
      step();
      start  = 1'b0;
   endtask

   int n_done;
   int first_done;

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; shamt = '0; rs_amt = '0;
      step(); step();
      reset = 1'b0;
      step();
      chk("reset_idle", {ShiftCtrl, ShiftSrc, ShiftOp, ShiftRegWrite, busy, done, err}, 10'd0);

      // SLL shamt=4
      go(3'd0, 5'd4, 5'd9);
      chk("sll_load_op", ShiftOp, 3'b001);
      chk("sll_ctrl", ShiftCtrl, 2'b10);
      chk("sll_busy", busy, 1'b1);
      step();
      chk("sll_shift_op", ShiftOp, 3'b010);
      step();
      chk("sll_done_wr", {done, ShiftRegWrite, ShiftOp}, {1'b1, 1'b1, 3'b000});
      step();
      chk("sll_back_idle", {busy, done}, 2'b00);

      // LUI
      go(3'd5, 5'd0, 5'd0);
      chk("lui_sel", {ShiftSrc, ShiftCtrl}, {1'b1, 2'b01});
      step();
      chk("lui_dir", ShiftOp, 3'b010);
      step();
      chk("lui_done", done, 1'b1);
      step();

      // SRAV with zero amount skips SHIFT
      go(3'd4, 5'd7, 5'd0);
      chk("srav0_load", ShiftOp, 3'b001);
      step();
      chk("srav0_done", {done, ShiftRegWrite, ShiftOp}, {1'b1, 1'b1, 3'b000});
      step();
      chk("srav0_idle", busy, 1'b0);

      // illegal op
      go(3'd7, 5'd3, 5'd3);
      chk("ill_err", {err, busy, ShiftOp}, {1'b1, 1'b0, 3'b000});
      step();
      chk("ill_err_pulse", err, 1'b0);

      // SRL aborted by reset in SHIFT
      go(3'd1, 5'd3, 5'd0);
      step();
      chk("srl_shift_op", ShiftOp, 3'b011);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("srl_abort", {busy, done, ShiftRegWrite}, 3'b000);
      step();
      chk("srl_no_late_done", {done, ShiftRegWrite}, 2'b00);

      // start held with SLL: completions every 4 cycles
      start = 1'b1; op = 3'd0; shamt = 5'd2; rs_amt = 5'd0;
      n_done = 0; first_done = -1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = k;
         end
      end
      start = 1'b0;
      chk("held_done_count", 10'(n_done), 10'd3);
      chk("held_first_done", 10'(first_done), 10'd3);
      step(); step(); step(); step();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         reset  = ($urandom_range(99) < 3);
         start  = ($urandom_range(1) == 1);
         op     = 3'($urandom_range(7));
         shamt  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
         rs_amt = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
         step();
      end
      reset = 1'b0; start = 1'b0;
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
